pc_fetch_sequencer: RTL and testbench

- Consumer side of the branch-target path: takes the held branch/jump target and redirects instruction fetch to it.
- Owns the 11-bit program counter and presents fetch addresses to instruction memory.
- Drives a pipeline flush window after every redirect, captures a link (return) address, and implements stall and halt.
- Sits at the front of the MINI-RISC pipeline, between the branch register/decode stage and instruction memory.

---
 rtl/mini_risc_pkg.sv | 16 +
 rtl/pc_fetch_sequencer_flush_timer.sv | 36 +++
 rtl/pc_fetch_sequencer.sv | 136 +++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mini_risc_pkg.sv
// Shared MINI-RISC front-end types: address width, reset vector and fetch FSM states.
package mini_risc_pkg;

   localparam int ADDR_W = 11;

   typedef logic [ADDR_W-1:0] addr_t;

   localparam addr_t RESET_VECTOR = 11'h000;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_FLUSH,
      ST_HALT
   } fetch_state_e;

endpackage

// File: rtl/pc_fetch_sequencer_flush_timer.sv
// Loadable down-counter: load wins over tick, counting stops at zero and done flags zero.
module flush_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   output logic         done
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (tick && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Front-end fetch sequencer: owns the PC, redirects to branch targets with a flush
// window, captures link addresses and parks in HALT until reset.
module pc_fetch_sequencer
   import mini_risc_pkg::*;
#(
   parameter int    FLUSH_CYCLES = 2,
   parameter addr_t RESET_VECTOR = mini_risc_pkg::RESET_VECTOR
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  stall,
   input  logic  redirect_en,
   input  addr_t redirect_addr,
   input  logic  link_en,
   input  logic  halt_req,
   output addr_t pc_out,
   output logic  fetch_valid,
   output logic  flush,
   output addr_t link_addr,
   output logic  halted
);

   localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 7)) begin : g_bad_flush_cycles
      $error("pc_fetch_sequencer: FLUSH_CYCLES must be in 1..7");
   end

   fetch_state_e state_q, state_d;
   addr_t        pc_q, pc_d;
   addr_t        link_q, link_d;
   logic         valid_q, valid_d;
   logic         flush_q, flush_d;
   logic         halted_q, halted_d;
   logic         timer_load, timer_tick, timer_done;

   flush_timer #(
      .W (CNT_W)
   ) u_flush_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (FLUSH_LOAD),
      .tick     (timer_tick),
      .done     (timer_done)
   );

   // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      link_d     = link_q;
      valid_d    = valid_q;
      flush_d    = 1'b0;
      halted_d   = halted_q;
      timer_load = 1'b0;
      timer_tick = 1'b0;

      unique case (state_q)
         ST_RUN: begin
            if (halt_req) begin
               state_d  = ST_HALT;
               valid_d  = 1'b0;
               flush_d  = 1'b1;
               halted_d = 1'b1;
            end else if (redirect_en) begin
               state_d    = ST_FLUSH;
               pc_d       = redirect_addr;
               valid_d    = 1'b0;
               flush_d    = 1'b1;
               timer_load = 1'b1;
               if (link_en) begin
                  link_d = pc_q + addr_t'(1);
               end
            end else if (!stall) begin
               // The first fetch after reset presents the reset vector itself.
               pc_d    = valid_q ? pc_q + addr_t'(1) : pc_q;
               valid_d = 1'b1;
            end
         end
         ST_FLUSH: begin
            timer_tick = 1'b1;
            if (halt_req) begin
               state_d  = ST_HALT;
               valid_d  = 1'b0;
               flush_d  = 1'b1;
               halted_d = 1'b1;
            end else if (redirect_en) begin
               pc_d       = redirect_addr;
               valid_d    = 1'b0;
               flush_d    = 1'b1;
               timer_load = 1'b1;
            end else if (timer_done) begin
               state_d = ST_RUN;
               valid_d = 1'b1;
            end else begin
               valid_d = 1'b0;
               flush_d = 1'b1;
            end
         end
         ST_HALT: begin
            valid_d  = 1'b0;
            halted_d = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_VECTOR;
         link_q   <= '0;
         valid_q  <= 1'b0;
         flush_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         link_q   <= link_d;
         valid_q  <= valid_d;
         flush_q  <= flush_d;
         halted_q <= halted_d;
      end
   end

   assign pc_out      = pc_q;
   assign fetch_valid = valid_q;
   assign flush       = flush_q;
   assign link_addr   = link_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer (FLUSH_CYCLES = 2, RESET_VECTOR = 0).
module tb_pc_fetch_sequencer;
   import mini_risc_pkg::*;

   logic  clk = 1'b0;
   logic  reset;
   logic  stall;
   logic  redirect_en;
   addr_t redirect_addr;
   logic  link_en;
   logic  halt_req;
   addr_t pc_out;
   logic  fetch_valid;
   logic  flush;
   addr_t link_addr;
   logic  halted;

   int tests  = 0;
   int failed = 0;

   pc_fetch_sequencer #(
      .FLUSH_CYCLES (2),
      .RESET_VECTOR (11'h000)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .redirect_en   (redirect_en),
      .redirect_addr (redirect_addr),
      .link_en       (link_en),
      .halt_req      (halt_req),
      .pc_out        (pc_out),
      .fetch_valid   (fetch_valid),
      .flush         (flush),
      .link_addr     (link_addr),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   // Advance one rising edge; outputs are then sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input addr_t pc, input logic v,
                             input logic f, input logic h, input addr_t lk);
      check({tag, ".pc"},     32'(pc_out),      32'(pc));
      check({tag, ".valid"},  32'(fetch_valid), 32'(v));
      check({tag, ".flush"},  32'(flush),       32'(f));
      check({tag, ".halted"}, 32'(halted),      32'(h));
      check({tag, ".link"},   32'(link_addr),   32'(lk));
   endtask

   task automatic clear_inputs();
      stall         = 1'b0;
      redirect_en   = 1'b0;
      redirect_addr = '0;
      link_en       = 1'b0;
      halt_req      = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      step();
      step();
      expect_out("reset", 11'h000, 1'b0, 1'b0, 1'b0, 11'h000);

      // 1: free run from reset
      reset = 1'b0;
      step(); expect_out("run0", 11'h000, 1'b1, 1'b0, 1'b0, 11'h000);
      step(); expect_out("run1", 11'h001, 1'b1, 1'b0, 1'b0, 11'h000);
      step(); expect_out("run2", 11'h002, 1'b1, 1'b0, 1'b0, 11'h000);
      step(); expect_out("run3", 11'h003, 1'b1, 1'b0, 1'b0, 11'h000);
      step(); step();
      expect_out("run5", 11'h005, 1'b1, 1'b0, 1'b0, 11'h000);

      // 2: redirect with link capture
      redirect_en = 1'b1; redirect_addr = 11'h040; link_en = 1'b1;
      step(); expect_out("redir_f1", 11'h040, 1'b0, 1'b1, 1'b0, 11'h006);
      clear_inputs();
      step(); expect_out("redir_f2", 11'h040, 1'b0, 1'b1, 1'b0, 11'h006);
      step(); expect_out("redir_v0", 11'h040, 1'b1, 1'b0, 1'b0, 11'h006);
      step(); expect_out("redir_v1", 11'h041, 1'b1, 1'b0, 1'b0, 11'h006);

      // 3: wrap at the top of the address space; link_en alone has no effect
      redirect_en = 1'b1; redirect_addr = 11'h7FE;
      step(); clear_inputs();
      step();
      link_en = 1'b1;
      step(); expect_out("wrap_7fe", 11'h7FE, 1'b1, 1'b0, 1'b0, 11'h006);
      step(); expect_out("wrap_7ff", 11'h7FF, 1'b1, 1'b0, 1'b0, 11'h006);
      step(); expect_out("wrap_000", 11'h000, 1'b1, 1'b0, 1'b0, 11'h006);
      step(); expect_out("wrap_001", 11'h001, 1'b1, 1'b0, 1'b0, 11'h006);
      clear_inputs();

      // 4: stall holds PC, redirect beats stall, stall ignored during flush
      redirect_en = 1'b1; redirect_addr = 11'h010;
      step(); clear_inputs();
      step(); step();
      expect_out("stall_at10", 11'h010, 1'b1, 1'b0, 1'b0, 11'h006);
      stall = 1'b1;
      step(); expect_out("stall_c1", 11'h010, 1'b1, 1'b0, 1'b0, 11'h006);
      step(); expect_out("stall_c2", 11'h010, 1'b1, 1'b0, 1'b0, 11'h006);
      step(); expect_out("stall_c3", 11'h010, 1'b1, 1'b0, 1'b0, 11'h006);
      redirect_en = 1'b1; redirect_addr = 11'h200;
      step(); expect_out("stall_redir_f1", 11'h200, 1'b0, 1'b1, 1'b0, 11'h006);
      redirect_en = 1'b0;
      step(); expect_out("stall_redir_f2", 11'h200, 1'b0, 1'b1, 1'b0, 11'h006);
      step(); expect_out("stall_redir_v0", 11'h200, 1'b1, 1'b0, 1'b0, 11'h006);
      stall = 1'b0;
      step(); expect_out("stall_redir_v1", 11'h201, 1'b1, 1'b0, 1'b0, 11'h006);

      // 5: second redirect in FLUSH restarts the window; link_en ignored there
      redirect_en = 1'b1; redirect_addr = 11'h100;
      step(); expect_out("rr_f1", 11'h100, 1'b0, 1'b1, 1'b0, 11'h006);
      redirect_addr = 11'h300; link_en = 1'b1;
      step(); expect_out("rr_f2", 11'h300, 1'b0, 1'b1, 1'b0, 11'h006);
      clear_inputs();
      step(); expect_out("rr_f3", 11'h300, 1'b0, 1'b1, 1'b0, 11'h006);
      step(); expect_out("rr_v0", 11'h300, 1'b1, 1'b0, 1'b0, 11'h006);

      // 6: halt beats redirect, HALT ignores inputs, reset leaves HALT at once
      halt_req = 1'b1; redirect_en = 1'b1; redirect_addr = 11'h555;
      step(); expect_out("halt_enter", 11'h300, 1'b0, 1'b1, 1'b1, 11'h006);
      clear_inputs();
      step(); expect_out("halt_hold", 11'h300, 1'b0, 1'b0, 1'b1, 11'h006);
      redirect_en = 1'b1; redirect_addr = 11'h123; link_en = 1'b1; stall = 1'b1;
      step(); expect_out("halt_ignore", 11'h300, 1'b0, 1'b0, 1'b1, 11'h006);
      step(); expect_out("halt_ignore2", 11'h300, 1'b0, 1'b0, 1'b1, 11'h006);
      clear_inputs();
      reset = 1'b1;
      #1;
      expect_out("halt_reset", 11'h000, 1'b0, 1'b0, 1'b0, 11'h000);
      step();
      reset = 1'b0;
      step(); expect_out("post_reset", 11'h000, 1'b1, 1'b0, 1'b0, 11'h000);
      step(); expect_out("post_reset1", 11'h001, 1'b1, 1'b0, 1'b0, 11'h000);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
